sipp_dmem_responder: RTL
========================

Name: sipp_dmem_responder

Overview:
- Responder end of the SIPP data-memory interface. Serves the d_rd/d_wr strobes that the controller issues during execute.
- Backs them with a word RAM plus a small memory-mapped I/O page:
  - an output stream behind a TX FIFO
  - a single-entry input holding register
  - a status word
  - a free-running cycle counter
- Sits between the SIPP datapath/controller and the external testbench or host stream ports.

Parameters:
ADDR_W, 8, data address width
MEM_WORDS, 240, RAM words at addresses 0..MEM_WORDS-1; must be <= IO_BASE
IO_BASE, 8'hFC, first of four I/O addresses: IO_BASE+0..IO_BASE+3
TX_DEPTH, 4, TX FIFO entries; power of two, 2..16

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
d_rd  in  1  read strobe from controller
d_wr  in  1  write strobe from controller
d_addr  in  ADDR_W  word address
d_w_data  in  16  write data
d_r_data  out  16  read data, combinational from d_addr/state
out_valid  out  1  TX FIFO head valid
out_data  out  16  TX FIFO head word
out_ready  in  1  downstream accepts head
in_valid  in  1  upstream word offered
in_data  in  16  upstream word
in_ready  out  1  holding register empty (= !rx_valid)

Behaviour:
- Reset (rst=0, asynchronous):
  - TX FIFO empty; out_valid=0; out_data=0.
  - rx_valid=0, so in_ready=1.
  - rx_data=0, cycle=0, ovf=0.
  - RAM contents are not cleared.
  - Reset mid-transfer discards all FIFO and RX contents.
- Address map:
  - RAM: 0..MEM_WORDS-1.
  - OUT = IO_BASE+0; STATUS = IO_BASE+1; IN = IO_BASE+2; CYC = IO_BASE+3.
  - Any other address: reads return 0; writes are ignored.
- Read path (zero latency):
  - d_r_data is valid in the same cycle d_rd is high, because the controller writes the register file in that same execute cycle.
  - d_r_data = 0 whenever d_rd=0.
- RAM:
  - Write occurs on the rising edge when d_wr=1 and the address is in range.
  - A read of the same address in the same cycle returns the old word.
- OUT:
  - Write pushes d_w_data into the TX FIFO.
  - If the FIFO is full and no pop happens that cycle, the word is dropped and ovf is set (sticky).
  - If the FIFO is full and a pop happens that cycle, the push is accepted and the count is unchanged.
  - Read of OUT returns 0.
- TX stream:
  - Pop when out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo TX_DEPTH.
- STATUS read: bit0 tx_full; bit1 tx_empty; bit2 rx_valid; bit3 ovf; bits[8:4] tx_count; other bits 0.
- STATUS write: any value clears ovf. If ovf is set by a dropped push in the same cycle, the set wins.
- IN read:
  - Returns rx_data; rx_valid clears on that edge if it was 1.
  - With rx_valid=0, the read returns 0 and has no side effect.
- RX capture:
  - When in_valid && in_ready: rx_data <= in_data, rx_valid <= 1.
  - An IN read in the same cycle that rx_valid=1 cannot coincide with a capture, because in_ready=0.
- CYC:
  - Counts +1 every cycle and wraps 16'hFFFF -> 0.
  - Read returns the current value.
  - Write loads 0; the count resumes next cycle.
- d_rd and d_wr both high:
  - The write side effect occurs.
  - Read side effects (IN pop) are suppressed.
  - d_r_data is still driven.
- There is no internal FSM beyond the FIFO pointers/count, rx_valid and ovf. The block never stalls the controller.

Test Plan:
- Reset, then: write 0x1234 @0x05; read @0x05 -> d_r_data=0x1234 same cycle. Read @0xF5 (unmapped) -> 0x0000.
- Hold out_ready=0 and push 5 words 0xA0..0xA4 to OUT:
  - Before the fifth push: STATUS = 0x0041 (count 4, full).
  - After the fifth push (dropped): STATUS = 0x0049 (ovf set).
  - Then out_ready=1 -> out_data sequence 0xA0,0xA1,0xA2,0xA3; then out_valid=0 and STATUS = 0x000A.
- FIFO full, out_ready=1, push 0xBB in the same cycle -> count stays 4; 0xBB emerges after the existing four words.
- in_valid=1, in_data=0x5A5A -> in_ready drops the next cycle and STATUS bit2=1.
  - Read IN -> 0x5A5A, and in_ready=1 the following cycle.
  - A second read of IN -> 0x0000.
- Write CYC (any value), idle 3 cycles, read CYC -> 0x0003. Also preload the counter through reset-release timing and confirm it wraps 0xFFFF -> 0x0000.
- Assert rst=0 asynchronously mid-stream with the FIFO holding 3 words and rx_valid=1:
  - Outputs go immediately to out_valid=0 and in_ready=1.
  - STATUS reads 0x0002 after release.
  - The RAM word written earlier is retained.

Source files
------------

// File: rtl/sipp_dmem_responder.sv
// sipp_dmem_responder: data-memory responder for the SIPP controller.
// Serves zero-latency reads and edge-timed writes from a word RAM plus
// four I/O words at IO_BASE..IO_BASE+3:
//   +0 OUT   : write pushes into the TX FIFO, read returns 0
//   +1 STATUS: {tx_count[8:4], ovf, rx_valid, tx_empty, tx_full}; write clears ovf
//   +2 IN    : read returns and consumes the RX holding register
//   +3 CYC   : free-running cycle counter; write loads 0
// Ports:
//   clk, rst (async, active-low)
//   d_rd, d_wr, d_addr, d_w_data, d_r_data : controller data-memory strobes
//   out_valid, out_data, out_ready          : TX stream (FIFO head)
//   in_valid, in_data, in_ready             : RX stream (single holding register)
module sipp_dmem_responder #(
    parameter int                ADDR_W    = 8,
    parameter int                MEM_WORDS = 240,
    parameter logic [ADDR_W-1:0] IO_BASE   = 8'hFC,
    parameter int                TX_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_w_data,
    output logic [15:0]       d_r_data,
    output logic              out_valid,
    output logic [15:0]       out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [ADDR_W-1:0] A_OUT = IO_BASE;
    localparam logic [ADDR_W-1:0] A_ST  = IO_BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IN  = IO_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CYC = IO_BASE + ADDR_W'(3);

    logic [15:0]   mem_q [MEM_WORDS];
    logic [15:0]   buf_q [TX_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          rxv_q, rxv_d, ovf_q, ovf_d;
    logic [15:0]   rx_q, rx_d, cyc_q, cyc_d, rd_mux;
    logic          in_ram, full, push, pop, acc, drop, in_rd, cap;

    always_comb begin
        in_ram = d_addr < ADDR_W'(MEM_WORDS);
        full   = cnt_q == (PW+1)'(TX_DEPTH);
        pop    = out_valid && out_ready;
        push   = d_wr && d_addr == A_OUT;
        // a pop in the same cycle frees the slot a full FIFO needs
        acc    = push && (!full || pop);
        drop   = push && full && !pop;
        // IN pop is a read side effect, suppressed when a write is also present
        in_rd  = d_rd && !d_wr && d_addr == A_IN && rxv_q;
        cap    = in_valid && !rxv_q;
        wp_d   = acc ? wp_q + 1'b1 : wp_q;
        rp_d   = pop ? rp_q + 1'b1 : rp_q;
        cnt_d  = cnt_q + (PW+1)'(acc) - (PW+1)'(pop);
        ovf_d  = drop || (ovf_q && !(d_wr && d_addr == A_ST));
        rxv_d  = cap || (rxv_q && !in_rd);
        rx_d   = cap ? in_data : rx_q;
        cyc_d  = (d_wr && d_addr == A_CYC) ? 16'h0 : cyc_q + 16'h1;
        rd_mux = in_ram           ? mem_q[d_addr] :
                 d_addr == A_ST   ? {7'b0, 5'(cnt_q), ovf_q, rxv_q, ~|cnt_q, full} :
                 d_addr == A_IN   ? (rxv_q ? rx_q : 16'h0) :
                 d_addr == A_CYC  ? cyc_q : 16'h0;
    end

    assign d_r_data  = d_rd ? rd_mux : 16'h0;
    assign out_valid = |cnt_q;
    assign out_data  = out_valid ? buf_q[rp_q] : 16'h0;
    assign in_ready  = !rxv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            rxv_q <= 1'b0;
            ovf_q <= 1'b0;
            rx_q  <= 16'h0;
            cyc_q <= 16'h0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            rxv_q <= rxv_d;
            ovf_q <= ovf_d;
            rx_q  <= rx_d;
            cyc_q <= cyc_d;
        end
    end

    // storage arrays are not reset; the FIFO head is gated by out_valid
    always_ff @(posedge clk) begin
        if (d_wr && in_ram) mem_q[d_addr] <= d_w_data;
        if (acc) buf_q[wp_q] <= d_w_data;
    end
endmodule
